// File: rtl/array_pack_if.sv
// Handshake bundle between an element producer, the packer and a packed-word consumer.
// slave:  the packer's view (sinks elements, sources packed words).
// master: the environment's view (sources elements, sinks packed words).
interface array_pack_if #(
    parameter int WA = 8,
    parameter int WB = 8
);
    localparam int CW = $clog2(WA + 1);

    logic                   s_valid;
    logic                   s_ready;
    logic [WB-1:0]          s_data;
    logic                   s_last;
    logic                   m_valid;
    logic                   m_ready;
    logic [WA-1:0][WB-1:0]  m_data;
    logic [CW-1:0]          m_cnt;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_cnt
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_cnt
    );
endinterface

// File: rtl/array_pack.sv
// Packs a stream of WB-bit elements into a [WA-1:0][WB-1:0] word. Element k of a
// packet lands in slice k; a packet closes after WA elements or on s_last.
// The output register is a one-deep buffer; s_ready is the only combinational output.
module array_pack #(
    parameter int WA = 8,
    parameter int WB = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    array_pack_if.slave   bus
);
    localparam int CW = $clog2(WA + 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e                 state_q;
    logic [WA-1:0][WB-1:0]  acc_q, acc_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WA-1:0][WB-1:0]  mdata_q, word_d;
    logic [CW-1:0]          mcnt_q;
    logic                   s_fire;
    logic                   closing;

    // A new element can always enter when the output slot is free or being drained.
    assign bus.s_ready = (state_q == EMPTY) || bus.m_ready;
    assign s_fire      = bus.s_valid && bus.s_ready;
    assign closing     = s_fire && (bus.s_last || (cnt_q == CW'(WA - 1)));

    assign bus.m_valid = (state_q == FULL);
    assign bus.m_data  = mdata_q;
    assign bus.m_cnt   = mcnt_q;

    // Assemble the closing word: collected elements, the closing element, zeros above.
    always_comb begin
        word_d = '0;
        for (int k = 0; k < WA; k++) begin
            if (k < int'(cnt_q)) begin
                word_d[k] = acc_q[k];
            end else if (k == int'(cnt_q)) begin
                word_d[k] = bus.s_data;
            end
        end
    end

    // Next accumulator/fill count: store into the current slot, or clear on close.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (closing) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (s_fire) begin
            for (int k = 0; k < WA; k++) begin
                if (k == int'(cnt_q)) begin
                    acc_d[k] = bus.s_data;
                end
            end
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Fill side: accumulator and element counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    // Output side FSM: a closing load wins over a concurrent drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            mdata_q <= '0;
            mcnt_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (closing) begin
                        state_q <= FULL;
                        mdata_q <= word_d;
                        mcnt_q  <= cnt_q + CW'(1);
                    end
                end
                FULL: begin
                    if (closing) begin
                        state_q <= FULL;
                        mdata_q <= word_d;
                        mcnt_q  <= cnt_q + CW'(1);
                    end else if (bus.m_ready) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end
endmodule

// File: doc/array_pack.md
# array_pack

Packs a stream of WB-bit elements into a packed two-dimensional word `[WA-1:0][WB-1:0]`, with valid/ready handshakes on both sides. It is the upstream producer for the packed-array consumers in this codebase. Element k of a packet lands in `m_data[k]`: the first element goes to the LSB slice and the last to the MSB slice. A packet closes when WA elements have been collected or when an element flagged `s_last` is accepted, whichever comes first.

## Interface
- `WA`, 8, number of elements per packed word (≥2)
- `WB`, 8, element width in bits (≥1)
- `CW`, $clog2(WA+1), width of the element count (derived localparam, not overridable)

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `s_valid`  in  1  input element valid
- `s_ready`  out  1  input element ready
- `s_data`  in  WB  input element
- `s_last`  in  1  input element closes the current packet
- `m_valid`  out  1  packed word valid
- `m_ready`  in  1  packed word accepted
- `m_data`  out  [WA-1:0][WB-1:0]  packed word, element k at index k
- `m_cnt`  out  CW  number of valid elements in `m_data`, range 1..WA

## Operation
- **Transfers:**
  - An input transfer happens on `s_valid && s_ready`.
  - An output transfer happens on `m_valid && m_ready`.
- **Internal state:**
  - Accumulator `acc [WA-1:0][WB-1:0]`.
  - Fill counter `cnt`, range 0..WA-1.
  - Output register `m_data` / `m_cnt` / `m_valid`.
- **Input ready:** `s_ready = !m_valid || m_ready`. This is combinational from `m_ready`; there is no other dependency.
- **Non-closing input transfer** (`cnt < WA-1` and `!s_last`):
  - `acc[cnt] <= s_data`.
  - `cnt <= cnt+1`.
- **Closing input transfer** (`cnt == WA-1` or `s_last`):
  - `m_data[k] <= acc[k]` for k < cnt.
  - `m_data[cnt] <= s_data`.
  - `m_data[k] <= '0` for k > cnt.
  - `m_cnt <= cnt+1`, `m_valid <= 1`.
  - `cnt <= 0` and `acc <= '0`.
- **Output transfer without a closing input transfer in the same cycle:** `m_valid <= 0`. `m_data` and `m_cnt` hold their old value; their contents are don't-care while `m_valid` is 0.
- **Output transfer together with a closing input transfer:** the load wins, so `m_valid` stays 1 and the new word is presented on the next cycle.
- **Unused elements:** elements above `m_cnt-1` are always zero in a valid word. Unused accumulator slots are never exposed.
- **`s_last` with `cnt == 0`:** produces a one-element word, `m_cnt == 1`.
- **Zero-length packets:** do not exist.
- **Input ignored while `!s_valid`:** `s_last` and `s_data` are ignored, and no state changes.
- **Output hold under backpressure:** while `m_valid && !m_ready`, `m_data` and `m_cnt` hold stable. `s_ready` is 0, so no input is accepted.
- **Reset:** asserting `rst_n` low at any time, including mid-packet or with a word pending, discards all partial and pending data. Values after reset:
  - `cnt = 0`, `acc = '0`
  - `m_valid = 0`, `m_data = '0`, `m_cnt = 0`
  - `s_ready = 1`, since it is combinational from `m_valid == 0`
- **State view (implicit FSM):**
  - Output side has two states, EMPTY (`m_valid = 0`) and FULL (`m_valid = 1`).
  - EMPTY → FULL on a closing input transfer.
  - FULL → EMPTY on an output transfer with no closing input transfer.
  - FULL → FULL on an output transfer together with a closing input transfer, or while `!m_ready`.
  - Fill side counts `cnt` 0 → WA-1 and wraps to 0 on any closing transfer.

## Timing
- **Latency:** the closing element is accepted on edge N; `m_valid` is high from edge N (visible in cycle N+1). There is no extra pipeline stage.
- **Throughput:** one element per cycle sustained while `m_ready` is held high. A full packet of WA elements yields one word every WA cycles, with no bubbles between packets.
- **Backpressure:** `m_ready` low with `m_valid` high drops `s_ready` in the same cycle. Raising `m_ready` re-enables `s_ready` in the same cycle.
- **Registered outputs:** `m_valid`, `m_data` and `m_cnt` are registered; `s_ready` is the only combinational output.
- **Reset release:** the first transfer may occur on the first rising edge after `rst_n` deasserts.

## Test plan
- **Full packet:** WA=8, WB=8; send 0x01..0x08, `s_last` low throughout, `m_ready` high.
  - Required: exactly one word, `m_data` = 64'h0807060504030201, `m_cnt` = 8.
  - Required: `m_valid` high in the cycle after the 8th transfer, for one cycle.
- **Short packet:** send 0xAA, 0xBB, then 0xCC with `s_last`; follow with a single 0x55 with `s_last`.
  - Required: first word `m_data` = 64'h0000000000CCBBAA, `m_cnt` = 3.
  - Required: second word `m_data` = 64'h0000000000000055, `m_cnt` = 1.
- **Backpressure:** hold `m_ready` low for 5 cycles after a word completes while `s_valid` stays high.
  - Required: `m_data` and `m_cnt` are stable and `s_ready` is 0 for all 5 cycles.
  - Required: on `m_ready` high the word is taken, the next element is accepted in the same cycle, and no element is lost or duplicated.
- **Back-to-back:** stream 32 elements 0x00..0x1F with `m_ready` and `s_valid` held high.
  - Required: 4 words at 8-cycle spacing, with `s_ready` constantly 1.
  - Required: word 3 = 64'h1F1E1D1C1B1A1918.
- **Reset mid-packet:** pulse `rst_n` low after 3 elements are accepted, then send 0x11..0x18.
  - Required: all outputs at reset values while `rst_n` is low.
  - Required: the next word is 64'h1817161514131211 with `m_cnt` = 8, containing no pre-reset data.
- **Random soak:** random `s_valid`, `m_ready` and `s_last`, checked against a queue-based reference model.
  - Required: word contents, `m_cnt`, zero fill of unused elements, and the handshake invariants all match.
